// File: rtl/tb_jtag_regcmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_pkg
// Description : Shared types and constants for the JTAG register-command
//               client: FSM encoding, opcode values, burst-count sizing and
//               the header-byte count decoder.
// Revision    : 1.0  initial release
// ============================================================================
package tb_jtag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } regcmd_state_t;

  // Flat state constants so the FSM register stays a plain logic vector.
  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_hdr  = HDR;
  localparam logic [1:0] c_st_addr = ADDR;
  localparam logic [1:0] c_st_data = DATA;

  localparam logic OP_WRITE  = 1'b0;
  localparam logic OP_READ   = 1'b1;
  localparam int   MAX_COUNT = 64;

  // Wide enough to hold MAX_COUNT+1, the index of the last byte.
  localparam int c_cnt_w = $clog2(MAX_COUNT) + 1;
  typedef logic [c_cnt_w-1:0] cnt_t;

  // Header byte carries count-1 in bits [7:2].
  function automatic cnt_t hdr_count(input logic [7:0] hdr);
    return cnt_t'(hdr[7:2]) + cnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tb_jtag_regcmd_rdpipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_regcmd_rdpipe
// Description : DEPTH-deep valid shift register. Tracks each issued read so
//               that the stage-(DEPTH-1) flag is high exactly in the cycle
//               the register bus presents the read data. An abort flushes
//               every in-flight read.
// Ports       : sysclk   - clock
//               sys_rstn - asynchronous active-low reset
//               i_issue  - a read strobe is being launched at this edge
//               i_abort  - discard all in-flight reads
//               o_valid  - bus_rdata belongs to a live read this cycle
// Revision    : 1.0  initial release
// ============================================================================
module tb_regcmd_rdpipe
  import tb_jtag_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic sysclk,
  input  logic sys_rstn,
  input  logic i_issue,
  input  logic i_abort,
  output logic o_valid
);

  logic [DEPTH-1:0] r_vld;

  generate
    if (DEPTH == 1) begin : g_depth1
      always_ff @(posedge sysclk or negedge sys_rstn) begin
        if (!sys_rstn) r_vld <= '0;
        else           r_vld <= i_abort ? 1'b0 : i_issue;
      end
    end else begin : g_depthn
      always_ff @(posedge sysclk or negedge sys_rstn) begin
        if (!sys_rstn)    r_vld <= '0;
        else if (i_abort) r_vld <= '0;
        else              r_vld <= {r_vld[DEPTH-2:0], i_issue};
      end
    end
  endgenerate

  assign o_valid = r_vld[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/tb_jtag_regcmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_regcmd
// Description : Command client for the JTAG byte-stream adapter. Decodes
//               read/write burst commands into strobes on an 8-bit register
//               bus and returns read data to the adapter.
//               Command: byte0 = {count-1[5:0], op, 0}, byte1 = address,
//               then count data/dummy bytes.
//               Optional build macro TB_JTAG_REGCMD_ECHO_EN: echo every
//               write data byte back on to_jtag one cycle after it arrives.
// Ports       : sysclk, sys_rstn     - clock, async active-low reset
//               start_cmd            - adapter saw a command start bit
//               cmd_data_rdy         - from_jtag holds a new byte
//               from_jtag[7:0]       - received command byte
//               jtag_inactive        - user register deselected, abort
//               cmd_finishing        - pulse after second-to-last byte
//               rsp_data_rdy         - pulse, to_jtag updated
//               to_jtag[7:0]         - response byte
//               bus_addr/bus_wdata   - register bus address / write data
//               bus_we/bus_re        - one-cycle write / read strobes
//               bus_rdata[7:0]       - read data
//               busy                 - FSM not idle
// Timing      : bus_rdata is sampled on the RD_LATENCY-th rising edge after
//               the edge that raised bus_re, so rsp_data_rdy rises exactly
//               RD_LATENCY cycles after bus_re (RD_LATENCY=1 expects a
//               combinational read port).
// Revision    : 1.0  initial release
// ============================================================================
module tb_jtag_regcmd
  import tb_jtag_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int ADDR_AUTOINC = 1
) (
  input  logic       sysclk,
  input  logic       sys_rstn,
  input  logic       start_cmd,
  input  logic       cmd_data_rdy,
  input  logic [7:0] from_jtag,
  input  logic       jtag_inactive,
  output logic       cmd_finishing,
  output logic       rsp_data_rdy,
  output logic [7:0] to_jtag,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  output logic       busy
);

  localparam logic [7:0] c_addr_step = (ADDR_AUTOINC != 0) ? 8'd1 : 8'd0;

  logic [1:0] r_state;
  logic       r_op;
  cnt_t       r_count;
  cnt_t       r_idx;
  logic [7:0] r_addr;     // address of the next bus access

  logic       w_busy;
  logic       w_abort;
  logic       w_byte;
  logic       w_last;
  logic       w_rd_issue;
  logic       w_wr_issue;
  logic [7:0] w_acc_addr;
  logic       w_rd_valid;

  assign w_busy  = (r_state != c_st_idle);
  assign w_abort = jtag_inactive | (start_cmd & w_busy);
  assign w_byte  = cmd_data_rdy & ~jtag_inactive;
  assign w_last  = (r_idx == (r_count + cnt_t'(1)));
  assign busy    = w_busy;

  // The first read goes straight to the address byte being received.
  assign w_acc_addr = (r_state == c_st_addr) ? from_jtag : r_addr;

  always_comb begin
    w_rd_issue = 1'b0;
    w_wr_issue = 1'b0;
    if (w_byte && (r_op == OP_READ) && !start_cmd) begin
      // A byte coincident with start_cmd is the old command's final byte,
      // so it never launches a further read.
      if (r_state == c_st_addr)               w_rd_issue = 1'b1;
      else if (r_state == c_st_data && !w_last) w_rd_issue = 1'b1;
    end
    if (w_byte && (r_op == OP_WRITE) && (r_state == c_st_data)) begin
      w_wr_issue = 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state       <= c_st_idle;
      r_op          <= OP_WRITE;
      r_count       <= '0;
      r_idx         <= '0;
      r_addr        <= '0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_we        <= 1'b0;
      bus_re        <= 1'b0;
      cmd_finishing <= 1'b0;
    end else begin
      bus_we        <= w_wr_issue;
      bus_re        <= w_rd_issue;
      cmd_finishing <= 1'b0;

      if (w_wr_issue) bus_wdata <= from_jtag;

      if (w_rd_issue || w_wr_issue) begin
        bus_addr <= w_acc_addr;
        r_addr   <= w_acc_addr + c_addr_step;
      end else if (w_byte && r_state == c_st_addr) begin
        r_addr <= from_jtag;
      end

      if (jtag_inactive) begin
        r_state <= c_st_idle;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (start_cmd) r_state <= c_st_hdr;
          end
          c_st_hdr: begin
            if (cmd_data_rdy) begin
              r_op    <= from_jtag[1];
              r_count <= hdr_count(from_jtag);
              r_state <= c_st_addr;
            end
          end
          c_st_addr: begin
            if (cmd_data_rdy) begin
              cmd_finishing <= (r_count == cnt_t'(1));
              r_idx         <= cnt_t'(2);
              r_state       <= c_st_data;
            end
          end
          default: begin
            if (cmd_data_rdy) begin
              cmd_finishing <= (r_idx == r_count);
              if (w_last) r_state <= c_st_idle;
              else        r_idx   <= r_idx + cnt_t'(1);
            end
          end
        endcase
        // Restart wins over whatever the byte above decided.
        if (start_cmd && w_busy) r_state <= c_st_hdr;
      end
    end
  end

  tb_regcmd_rdpipe #(
    .DEPTH (RD_LATENCY)
  ) u_rdpipe (
    .sysclk   (sysclk),
    .sys_rstn (sys_rstn),
    .i_issue  (w_rd_issue),
    .i_abort  (w_abort),
    .o_valid  (w_rd_valid)
  );

  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      to_jtag      <= '0;
      rsp_data_rdy <= 1'b0;
    end else begin
      rsp_data_rdy <= 1'b0;
      if (w_rd_valid && !w_abort) begin
        to_jtag      <= bus_rdata;
        rsp_data_rdy <= 1'b1;
      end
`ifdef TB_JTAG_REGCMD_ECHO_EN
      else if (w_wr_issue) begin
        to_jtag      <= from_jtag;
        rsp_data_rdy <= 1'b1;
      end
`else
`endif
    end
  end

endmodule
`default_nettype wire
